// File: rtl/pipe_skid_reg_16.sv
// Pipeline stage register with valid/ready handshake on both sides and a one-entry skid slot.
// in_ready, out_valid and count decode from registered occupancy, so out_ready never reaches in_ready.
module pipe_skid_reg_16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             accept_s;
  logic             consume_s;

  assign out_valid = (state_q != ST_EMPTY);
  assign in_ready  = (state_q != ST_FULL);
  assign out_data  = main_q;
  assign accept_s  = in_valid & in_ready;
  assign consume_s = out_valid & out_ready;

  // Occupancy decode for the count output.
  always_comb begin
    count = 2'd0;
    case (state_q)
      ST_EMPTY: count = 2'd0;
      ST_ONE:   count = 2'd1;
      ST_FULL:  count = 2'd2;
      default:  count = 2'd0;
    endcase
  end

  // Next-state and datapath: flush squashes both slots; the skid item only moves into main on consume.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = {WIDTH{1'b0}};
      skid_d  = {WIDTH{1'b0}};
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept_s) begin
            state_d = ST_ONE;
            main_d  = in_data;
          end else begin
            state_d = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (accept_s && consume_s) begin
            main_d = in_data;
          end else if (accept_s) begin
            state_d = ST_FULL;
            skid_d  = in_data;
          end else if (consume_s) begin
            state_d = ST_EMPTY;
          end else begin
            state_d = ST_ONE;
          end
        end
        ST_FULL: begin
          if (consume_s) begin
            state_d = ST_ONE;
            main_d  = skid_q;
          end else begin
            state_d = ST_FULL;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          main_d  = {WIDTH{1'b0}};
          skid_d  = {WIDTH{1'b0}};
        end
      endcase
    end
  end

  // State and storage flops with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      main_q  <= {WIDTH{1'b0}};
      skid_q  <= {WIDTH{1'b0}};
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: doc/pipe_skid_reg_16.md
Name: pipe_skid_reg_16

Overview:
- 16-bit pipeline stage register with a valid/ready handshake on both sides and a one-entry skid slot.
- Sits between stages of the 5-stage CPU pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB). The upstream stage writes; the downstream stage reads.
- A downstream stall is absorbed for one cycle without combinational ready propagation, so in_ready is purely registered.
- Provides flush for branch/hazard squash.

Parameters:
- WIDTH, 16, payload width in bits.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- flush  input  1  synchronous squash; empties the stage
- in_valid  input  1  upstream has data on in_data
- in_ready  output  1  stage can accept; registered, no combinational path from out_ready
- in_data  input  WIDTH  upstream payload
- out_valid  output  1  out_data holds a valid item
- out_ready  input  1  downstream consumes when high with out_valid
- out_data  output  WIDTH  head item; driven from the main register
- count  output  2  occupancy: 0, 1 or 2

Behaviour:
- Storage: main register (head) and skid register. Occupancy state is EMPTY, ONE or FULL.
- Handshake events:
  - accept = in_valid & in_ready
  - consume = out_valid & out_ready
- Outputs decode from registered state only:
  - out_valid = (state != EMPTY)
  - in_ready = (state != FULL)
  - count = 0, 1 or 2 for EMPTY, ONE or FULL
- Reset (rst=1 at a clk edge): state=EMPTY, main=0, skid=0. Hence out_valid=0, in_ready=1, out_data=0, count=0. rst overrides flush and any handshake, including mid-transfer.
- Flush (rst=0, flush=1): state=EMPTY, main=0, skid=0. A simultaneous accept is discarded and a simultaneous consume is allowed but irrelevant. in_ready=1 in the next cycle.
- Transitions (rst=0, flush=0):
  - EMPTY: accept -> ONE, main<=in_data. Otherwise stay.
  - ONE, accept & consume -> ONE, main<=in_data (full throughput, 1 item/cycle).
  - ONE, accept & !consume -> FULL, skid<=in_data, main held.
  - ONE, !accept & consume -> EMPTY. main retains its value but out_valid=0.
  - ONE, neither -> hold.
  - FULL: in_ready=0, so no accept. consume -> ONE, main<=skid. Otherwise hold.
- Latency: an item accepted at edge N is visible on out_data/out_valid after edge N, i.e. 1 cycle.
- Ordering: strict FIFO. The skid item is never presented before the main item.
- Stability: while out_valid=1 and out_ready=0, out_data and out_valid do not change.
- Upstream contract: in_data is sampled only on accept. in_valid with in_ready=0 has no effect; upstream must hold.
- No overflow is possible: FULL forces in_ready=0. Underflow cannot occur: out_ready is ignored when EMPTY.
- All registers update only on the rising edge of clk. No asynchronous logic and no latches.

Test Plan:
- Reset: drive in_valid=1, in_data=16'hFFFF with rst=1 for 2 cycles -> out_valid=0, in_ready=1, out_data=16'h0000, count=0. After release with out_ready=0: one cycle later out_data=16'hFFFF, count=1.
- Streaming: out_ready=1 constantly; send 16'h0001..16'h0008 back-to-back -> each appears one cycle after accept, in order, in_ready stays 1, count never exceeds 1, 8 items in 9 cycles.
- Skid: load 16'hA5A5 (count=1), then drop out_ready and present 16'h5A5A -> count=2, in_ready=0, out_data=16'hA5A5 held. Raise out_ready -> next cycle out_data=16'h5A5A, count=1. Next cycle count=0 and out_valid=0.
- Backpressure hold: while FULL, toggle in_data randomly with in_valid=1 for 5 cycles -> no item accepted, out_data stable; order after release is exactly A5A5, 5A5A.
- Flush mid-operation: in FULL state assert flush with in_valid=1, in_data=16'h1234 -> next cycle count=0, out_valid=0, out_data=0, in_ready=1, and 16'h1234 never appears on the output.
- Reset while FULL, with out_ready=1: assert rst for one cycle -> all outputs return to reset values and neither queued item is emitted afterward.
